// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the front-panel key logic.
package clock_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES   = 500000;
   localparam int DEFAULT_LONG_PRESS_CYCLES = 50000000;
   localparam int DEFAULT_REPEAT_CYCLES     = 10000000;

   typedef enum logic [2:0] {
      KEY_IDLE,
      KEY_PRESS_DB,
      KEY_PRESSED,
      KEY_LONG,
      KEY_REL_DB
   } key_state_e;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchronizer, debounce/long-press FSM, shared counter and
// registered pulse/held outputs.
module key_debounce_cell
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
   parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES,
   parameter bit REPEAT_EN         = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_pulse,
   output logic key_held
);

   localparam int CNT_MAX = maxOf3(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pulse_q, pulse_d;
   logic             held_q, held_d;

   // Synchronizer idles at 1 so reset looks like "not pressed"
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], key_n};
      end
   end

   assign level = sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= KEY_IDLE;
         count_q <= '0;
         pulse_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
         held_q  <= held_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         KEY_IDLE: begin
            count_d = '0;
            if (!level) state_d = KEY_PRESS_DB;
         end
         KEY_PRESS_DB: begin
            if (level) begin
               state_d = KEY_IDLE;
               count_d = '0;
            end else if (count_q == DB_LAST) begin
               state_d = KEY_PRESSED;
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         KEY_PRESSED: begin
            if (level) begin
               state_d = KEY_REL_DB;
               count_d = '0;
            end else if (count_q == LONG_LAST) begin
               state_d = KEY_LONG;
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         KEY_LONG: begin
            if (level) begin
               state_d = KEY_REL_DB;
               count_d = '0;
            end else if (count_q == RPT_LAST) begin
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         KEY_REL_DB: begin
            // A bounce back to pressed resumes the press without a new event
            if (!level) begin
               state_d = KEY_PRESSED;
               count_d = '0;
            end else if (count_q == DB_LAST) begin
               state_d = KEY_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = KEY_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_comb begin
      pulse_d = 1'b0;
      if (state_q == KEY_PRESS_DB && state_d == KEY_PRESSED) pulse_d = 1'b1;
      if (REPEAT_EN && state_q == KEY_PRESSED && state_d == KEY_LONG) pulse_d = 1'b1;
      if (REPEAT_EN && state_q == KEY_LONG && state_d == KEY_LONG && count_q == RPT_LAST)
         pulse_d = 1'b1;
      held_d = (state_d == KEY_PRESSED) || (state_d == KEY_LONG) || (state_d == KEY_REL_DB);
   end

   assign key_pulse = pulse_q;
   assign key_held  = held_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Front-panel key controller: one debounce cell per key; key 0 is the mode key
// and drives the mode-advance strobe without auto-repeat.
module key_input_ctrl
   import clock_pkg::*;
#(
   parameter int NUM_KEYS          = 3,
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
   parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_pulse,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                set_module_en
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
         .REPEAT_CYCLES    (REPEAT_CYCLES),
         .REPEAT_EN        (i != 0)
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .key_n    (key_n[i]),
         .key_pulse(key_pulse[i]),
         .key_held (key_held[i])
      );
   end

   assign set_module_en = key_pulse[0];

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed, table-driven bench for key_input_ctrl with D=4, L=16, R=8.
module tb_key_input_ctrl;

   logic       clk;
   logic       rst_n;
   logic [2:0] key_n;
   logic [2:0] key_pulse;
   logic [2:0] key_held;
   logic       set_module_en;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         scen;
      logic       rstn;
      logic [2:0] kn;
      logic [2:0] pulse;
      logic [2:0] held;
   } vec_t;

   vec_t  vecs[$];
   string scenName[8] = '{"reset", "repeatKey1", "noRepeatKey0", "glitch",
                          "modeStrobes", "simultaneous", "bounce", "resetInLong"};

   key_input_ctrl #(
      .NUM_KEYS         (3),
      .DEBOUNCE_CYCLES  (4),
      .LONG_PRESS_CYCLES(16),
      .REPEAT_CYCLES    (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_n        (key_n),
      .key_pulse    (key_pulse),
      .key_held     (key_held),
      .set_module_en(set_module_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void addVec(input int s, input logic r, input logic [2:0] kn,
                                  input logic [2:0] p, input logic [2:0] h);
      vec_t v;
      v.scen  = s;
      v.rstn  = r;
      v.kn    = kn;
      v.pulse = p;
      v.held  = h;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input logic r, input logic [2:0] kn);
      @(negedge clk);
      rst_n = r;
      key_n = kn;
   endtask

   // Outputs are registered, so step i shows the result of the edge sampling step i's inputs
   task automatic checkOutput(input int s, input int idx, input logic [2:0] ep, input logic [2:0] eh);
      @(posedge clk);
      #1;
      checks++;
      if (key_pulse !== ep) begin
         failures++;
         $display("[TB] FAIL %s[%0d] key_pulse actual=%b required=%b", scenName[s], idx, key_pulse, ep);
      end
      checks++;
      if (key_held !== eh) begin
         failures++;
         $display("[TB] FAIL %s[%0d] key_held actual=%b required=%b", scenName[s], idx, key_held, eh);
      end
      checks++;
      if (set_module_en !== ep[0]) begin
         failures++;
         $display("[TB] FAIL %s[%0d] set_module_en actual=%b required=%b", scenName[s], idx, set_module_en, ep[0]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      key_n = 3'b111;

      for (int i = 0; i < 5; i++) addVec(0, (i >= 3), 3'b111, 3'b000, 3'b000);

      for (int i = 0; i < 50; i++)
         addVec(1, 1'b1, (i < 40) ? 3'b101 : 3'b111,
                (i == 6 || i == 22 || i == 30 || i == 38) ? 3'b010 : 3'b000,
                (i >= 6 && i <= 45) ? 3'b010 : 3'b000);

      for (int i = 0; i < 50; i++)
         addVec(2, 1'b1, (i < 40) ? 3'b110 : 3'b111,
                (i == 6) ? 3'b001 : 3'b000,
                (i >= 6 && i <= 45) ? 3'b001 : 3'b000);

      // 3- and 4-cycle glitches are rejected; 5 cycles low is the shortest accepted press
      for (int i = 0; i < 12; i++) addVec(3, 1'b1, (i < 3) ? 3'b110 : 3'b111, 3'b000, 3'b000);
      for (int i = 0; i < 12; i++) addVec(3, 1'b1, (i < 4) ? 3'b011 : 3'b111, 3'b000, 3'b000);
      for (int i = 0; i < 15; i++)
         addVec(3, 1'b1, (i < 5) ? 3'b110 : 3'b111,
                (i == 6) ? 3'b001 : 3'b000,
                (i >= 6 && i <= 10) ? 3'b001 : 3'b000);

      for (int r = 0; r < 4; r++)
         for (int i = 0; i < 20; i++)
            addVec(4, 1'b1, (i < 10) ? 3'b110 : 3'b111,
                   (i == 6) ? 3'b001 : 3'b000,
                   (i >= 6 && i <= 15) ? 3'b001 : 3'b000);

      for (int i = 0; i < 20; i++)
         addVec(5, 1'b1, (i < 10) ? 3'b010 : 3'b111,
                (i == 6) ? 3'b101 : 3'b000,
                (i >= 6 && i <= 15) ? 3'b101 : 3'b000);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rstn, vecs[i].kn);
         checkOutput(vecs[i].scen, i, vecs[i].pulse, vecs[i].held);
      end

      // Key 1 bounces high for two cycles just after acceptance
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b1, (i == 8 || i == 9 || i >= 20) ? 3'b111 : 3'b101);
         checkOutput(6, i, (i == 6) ? 3'b010 : 3'b000,
                     (i >= 6 && i <= 25) ? 3'b010 : 3'b000);
      end

      // Reset pulse while key 2 is in LONG; key remains held through and after reset
      for (int i = 0; i < 51; i++) begin
         applyStimulus(!(i == 25 || i == 26), (i <= 40) ? 3'b011 : 3'b111);
         checkOutput(7, i, (i == 6 || i == 22 || i == 33) ? 3'b100 : 3'b000,
                     ((i >= 6 && i <= 24) || (i >= 33 && i <= 46)) ? 3'b100 : 3'b000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
